// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one result bit per clock, LSB first, WIDTH+2 cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             br_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, zero_q;

    logic             bit_d, br_d;
    logic [WIDTH-1:0] acc_d, a_d, b_d;

    always_comb begin
        bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // Shift-then-overwrite keeps this legal for WIDTH=1.
        acc_d = acc_q >> 1;
        acc_d[WIDTH-1] = bit_d;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are captured separately because the shift registers lose them.
    logic a_msb_q, b_msb_q, ovf_q, ovf_d;

    always_comb begin
        ovf_d = (a_msb_q != b_msb_q) & (acc_d[WIDTH-1] != a_msb_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && start) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == RUN && cnt_q == LAST) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        diff_q   <= acc_d;
                        borrow_q <= br_d;
                        zero_q   <= (acc_d == '0);
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 Port: clk  input  1  system clock, rising-edge active.
REQ-003 Port: rst_n  input  1  asynchronous reset, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend, sampled at the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend, sampled at the accepting edge.
REQ-007 Port: busy  output  1  high while bits are being processed (RUN state).
REQ-008 Port: done  output  1  one-cycle pulse marking a new valid result.
REQ-009 Port: diff  output  WIDTH  registered result a-b, modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  registered final borrow; 1 when a<b unsigned.
REQ-011 Port: zero  output  1  registered flag; 1 when diff==0.
REQ-012 Port (only with SERIAL_SUB_OVF_EN): ovf  output  1  registered signed two's-complement overflow flag.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at a rising edge SHALL load a and b into internal shift registers, clear the borrow flop, clear the bit counter and enter RUN.
REQ-015 RUN: each edge SHALL process LSB bits a0, b0 with borrow flop br: d = a0^b0^br; br_next = (~a0&b0)|(~(a0^b0)&br).
REQ-016 RUN: d SHALL shift into the MSB of an internal accumulator, operand registers shift right by one, counter increments.
REQ-017 RUN SHALL last exactly WIDTH edges; at the WIDTH-th RUN edge, diff/borrow/zero (and ovf) SHALL be loaded from the completed accumulator and final br, and the state SHALL become DONE.
REQ-018 DONE: done=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge E0 -> done high in the cycle following edge E(WIDTH); IDLE again after E(WIDTH+1).
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both registered-state decodes.
REQ-021 start while in RUN or DONE SHALL be ignored; no queuing; a and b changes after acceptance SHALL NOT affect the result.
REQ-022 diff, borrow, zero, ovf SHALL hold their last values until the next result load (REQ-017); they SHALL NOT change during RUN.
REQ-023 WIDTH=1 SHALL work: RUN lasts one edge, done in the cycle after E1.
REQ-024 Back-to-back: start held high continuously SHALL yield one operation every WIDTH+2 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state IDLE and busy, done, diff, borrow, zero, ovf, counter, shift registers and borrow flop to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-027 First start SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SERIAL_SUB_OVF_EN defined: ovf port present; ovf = (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]), using the latched operand MSBs, loaded with diff.
REQ-029 Macro SERIAL_SUB_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 a=5, b=3, start pulse at E0 -> busy high for 8 cycles; done in the cycle after E8; diff=0x02, borrow=0, zero=0.
REQ-031 a=3, b=5 -> diff=0xFE, borrow=1, zero=0; with SERIAL_SUB_OVF_EN, ovf=0.
REQ-032 a=0x80, b=0x01 (macro on) -> diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
REQ-033 a=0x07, b=0x07 -> diff=0x00, zero=1, borrow=0; then start with a=9, b=1 pulsed at E3 of that RUN -> ignored, outputs unchanged until original done.
REQ-034 rst_n low for 1 cycle at E4 of RUN -> all outputs 0 immediately, no done; fresh start a=0xFF, b=0x00 -> diff=0xFF, borrow=0.
